// File: rtl/afb_pkg.sv
// Shared field positions, FSM encoding and register map for the AFB register file.
package afb_pkg;

    // Request word layout (74 bits; bit 73 is the lock flag, ignored).
    localparam int unsigned RwBit    = 72;
    localparam int unsigned MaskMsb  = 71;
    localparam int unsigned MaskLsb  = 68;
    localparam int unsigned AddrMsb  = 67;
    localparam int unsigned AddrLsb  = 32;
    localparam int unsigned WdataMsb = 31;

    // Response word layout (33 bits).
    localparam int unsigned RespErr  = 32;

    // Fixed register indices.
    localparam int unsigned CtrlIdx      = 0;
    localparam int unsigned IrqStatusIdx = 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } afb_state_e;

    // Replace only the bytes of old_val whose mask bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/afb_addr_decode.sv
// Combinational address decoder: word-aligned hit inside the register window plus index.
module afb_addr_decode
    import afb_pkg::*;
#(
    parameter logic [35:0] BASE_ADDR = 36'h0,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned IDX_W     = $clog2(NUM_REGS)
) (
    input  logic [35:0]      addr_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);

    // Base is aligned to the window size, so a hit is an exact match of the upper bits.
    localparam int unsigned     SpanW  = IDX_W + 2;
    localparam logic [35-SpanW:0] BaseHi = BASE_ADDR[35:SpanW];

    assign hit_o = (addr_i[35:SpanW] == BaseHi) && (addr_i[1:0] == 2'b00);
    assign idx_o = addr_i[SpanW-1:2];

endmodule

// File: rtl/afb_accel_regfile.sv
// AFB slave register file: request/access/response FSM, byte-masked bus writes,
// hardware update port and a maskable W1C interrupt.
module afb_accel_regfile
    import afb_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [35:0] BASE_ADDR = 36'h0,
    parameter int unsigned IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     afb_req_write_req,
    output logic                     afb_req_write_ack,
    input  logic [73:0]              afb_req_write_data,
    input  logic                     afb_resp_read_req,
    output logic                     afb_resp_read_ack,
    output logic [32:0]              afb_resp_read_data,
    input  logic                     hw_wr_en,
    input  logic [IDX_W-1:0]         hw_wr_idx,
    input  logic [31:0]              hw_wr_data,
    input  logic                     irq_set,
    output logic [32*NUM_REGS-1:0]   regs_flat,
    output logic                     busy,
    output logic                     accelerator_interrupt
);

    localparam logic [IDX_W-1:0] CtrlI = IDX_W'(CtrlIdx);
    localparam logic [IDX_W-1:0] StatI = IDX_W'(IrqStatusIdx);

    afb_state_e  state_q, state_d;
    logic        wr_ack_q, wr_ack_d;
    logic        rd_ack_q, rd_ack_d;
    logic [72:0] req_q;
    logic [32:0] resp_q, resp_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic        irq_q;

    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;
    logic             accept;
    logic             bus_wr;
    logic             req_rd;
    logic [3:0]       req_mask;
    logic [31:0]      req_wdata;
    logic             unused_lock;

    assign unused_lock = afb_req_write_data[73];
    assign accept      = afb_req_write_req & wr_ack_q;
    assign req_rd      = req_q[RwBit];
    assign req_mask    = req_q[MaskMsb:MaskLsb];
    assign req_wdata   = req_q[WdataMsb:0];
    assign bus_wr      = (state_q == StAccess) & dec_hit & ~req_rd;

    afb_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W)
    ) u_decode (
        .addr_i (req_q[AddrMsb:AddrLsb]),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    // Next state; acks are registered from the next state so they never follow req combinationally.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   if (afb_resp_read_req && rd_ack_q) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        wr_ack_d = (state_d == StIdle);
        rd_ack_d = (state_d == StResp);
    end

    // Register updates: hw port first, bus write overrides, irq_set wins over W1C.
    always_comb begin
        regs_d = regs_q;
        if (hw_wr_en && (hw_wr_idx != CtrlI) && (hw_wr_idx != StatI)) begin
            regs_d[hw_wr_idx] = hw_wr_data;
        end
        if (bus_wr) begin
            if (dec_idx == StatI) begin
                if (req_mask[0] && req_wdata[0]) regs_d[StatI][0] = 1'b0;
            end else begin
                regs_d[dec_idx] = byte_merge(regs_q[dec_idx], req_wdata, req_mask);
            end
        end
        if (irq_set) regs_d[StatI][0] = 1'b1;
        regs_d[StatI][31:1] = '0;
    end

    // Response word captured during ACCESS and held through RESP.
    always_comb begin
        resp_d = resp_q;
        if (state_q == StAccess) begin
            resp_d = '0;
            if (!dec_hit) begin
                resp_d[RespErr] = 1'b1;
            end else if (req_rd) begin
                resp_d[31:0] = regs_q[dec_idx];
            end
        end
    end

    // State, handshake, request latch, response, registers and interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            req_q    <= '0;
            resp_q   <= '0;
            regs_q   <= '{default: '0};
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ack_q <= wr_ack_d;
            rd_ack_q <= rd_ack_d;
            if (accept) req_q <= afb_req_write_data[72:0];
            resp_q   <= resp_d;
            regs_q   <= regs_d;
            irq_q    <= regs_q[CtrlI][0] & regs_q[StatI][0];
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_flat[32*i +: 32] = regs_q[i];
    end

    assign afb_req_write_ack     = wr_ack_q;
    assign afb_resp_read_ack     = rd_ack_q;
    assign afb_resp_read_data    = resp_q;
    assign busy                  = (state_q != StIdle);
    assign accelerator_interrupt = irq_q;

endmodule

// File: tb/tb_afb_accel_regfile.sv
// Directed bench for afb_accel_regfile with hand-computed expected values.
module tb_afb_accel_regfile;

    localparam logic [35:0] Base   = 36'h4000;
    localparam logic [32:0] RespOk = 33'h0;
    localparam logic [32:0] RespEr = 33'h1_0000_0000;

    logic         clk;
    logic         reset;
    logic         req;
    logic         wr_ack;
    logic [73:0]  req_data;
    logic         rd_req;
    logic         rd_ack;
    logic [32:0]  rd_data;
    logic         hw_en;
    logic [3:0]   hw_idx;
    logic [31:0]  hw_data;
    logic         irq_set;
    logic [511:0] regs_flat;
    logic         busy;
    logic         irq;

    int total = 0;
    int bad   = 0;

    afb_accel_regfile #(
        .NUM_REGS  (16),
        .BASE_ADDR (Base),
        .IDX_W     (4)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .afb_req_write_req     (req),
        .afb_req_write_ack     (wr_ack),
        .afb_req_write_data    (req_data),
        .afb_resp_read_req     (rd_req),
        .afb_resp_read_ack     (rd_ack),
        .afb_resp_read_data    (rd_data),
        .hw_wr_en              (hw_en),
        .hw_wr_idx             (hw_idx),
        .hw_wr_data            (hw_data),
        .irq_set               (irq_set),
        .regs_flat             (regs_flat),
        .busy                  (busy),
        .accelerator_interrupt (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return regs_flat[32*i +: 32];
    endfunction

    // One full transaction; optional hold in RESP with a competing request pending,
    // and optional irq_set / hw write driven during the ACCESS cycle.
    task automatic bus(input string tag, input logic rd, input logic [3:0] mask,
                       input logic [35:0] addr, input logic [31:0] wd, input int hold,
                       input logic irq_p, input logic hw_p, input logic [3:0] hidx,
                       input logic [31:0] hdat, input logic [32:0] exp);
        int n;
        @(negedge clk);
        req      = 1'b1;
        req_data = {1'b0, rd, mask, addr, wd};
        n = 0;
        while (wr_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check({tag, "_accept"}, {32'b0, wr_ack}, 33'd1);
            req = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req     = 1'b0;
        irq_set = irq_p;
        hw_en   = hw_p;
        hw_idx  = hidx;
        hw_data = hdat;
        @(negedge clk);
        check({tag, "_n1_ack"}, {32'b0, rd_ack}, 33'd0);
        @(posedge clk);
        #1;
        irq_set = 1'b0;
        hw_en   = 1'b0;
        @(negedge clk);
        check({tag, "_n2_ack"}, {32'b0, rd_ack}, 33'd1);
        check({tag, "_resp"}, rd_data, exp);
        for (int i = 0; i < hold; i++) begin
            req      = 1'b1;
            req_data = {1'b0, 1'b0, 4'hF, Base + 36'h8, 32'h0};
            @(negedge clk);
            check({tag, "_hold_ack"}, {32'b0, rd_ack}, 33'd1);
            check({tag, "_hold_data"}, rd_data, exp);
            check({tag, "_hold_wack"}, {32'b0, wr_ack}, 33'd0);
            check({tag, "_hold_busy"}, {32'b0, busy}, 33'd1);
        end
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        req    = 1'b0;
        @(negedge clk);
        check({tag, "_ack_drop"}, {32'b0, rd_ack}, 33'd0);
    endtask

    task automatic wr(input string tag, input logic [35:0] addr, input logic [3:0] mask,
                      input logic [31:0] wd, input logic [32:0] exp);
        bus(tag, 1'b0, mask, addr, wd, 0, 1'b0, 1'b0, 4'd0, 32'h0, exp);
    endtask

    task automatic rdc(input string tag, input logic [35:0] addr, input logic [32:0] exp);
        bus(tag, 1'b1, 4'h0, addr, 32'h0, 0, 1'b0, 1'b0, 4'd0, 32'h0, exp);
    endtask

    task automatic hw_poke(input logic [3:0] idx, input logic [31:0] d);
        @(negedge clk);
        hw_en   = 1'b1;
        hw_idx  = idx;
        hw_data = d;
        @(posedge clk);
        #1;
        hw_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_irq();
        @(negedge clk);
        irq_set = 1'b1;
        @(posedge clk);
        #1;
        irq_set = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        req      = 1'b0;
        req_data = '0;
        rd_req   = 1'b0;
        hw_en    = 1'b0;
        hw_idx   = '0;
        hw_data  = '0;
        irq_set  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wack", {32'b0, wr_ack}, 33'd0);
        check("rst_rack", {32'b0, rd_ack}, 33'd0);
        check("rst_rdata", rd_data, 33'd0);
        check("rst_busy", {32'b0, busy}, 33'd0);
        check("rst_irq", {32'b0, irq}, 33'd0);
        check("rst_flat", {32'b0, regs_flat != '0}, 33'd0);
        reset = 1'b0;

        // 1: full write then read back
        wr("t1_wr", Base + 36'h8, 4'hF, 32'hDEADBEEF, RespOk);
        rdc("t1_rd", Base + 36'h8, {1'b0, 32'hDEADBEEF});

        // 2: byte-masked write
        wr("t2_wr_a", Base + 36'hC, 4'hF, 32'hAAAAAAAA, RespOk);
        wr("t2_wr_b", Base + 36'hC, 4'b0101, 32'h11223344, RespOk);
        rdc("t2_rd", Base + 36'hC, {1'b0, 32'hAA22AA44});

        // 3: decode boundaries, misses and no-op mask
        rdc("t3_past_end", Base + 36'h40, RespEr);
        rdc("t3_unaligned", Base + 36'h6, RespEr);
        rdc("t3_below", Base - 36'h4, RespEr);
        wr("t3_wr_miss", Base + 36'h40, 4'hF, 32'h12345678, RespEr);
        wr("t3_wr_nomask", Base + 36'h8, 4'h0, 32'h0, RespOk);
        rdc("t3_rd_r2", Base + 36'h8, {1'b0, 32'hDEADBEEF});
        wr("t3_wr_last", Base + 36'h3C, 4'hF, 32'hCAFEF00D, RespOk);
        rdc("t3_rd_last", Base + 36'h3C, {1'b0, 32'hCAFEF00D});
        check("t3_flat_r3", {1'b0, reg_of(3)}, {1'b0, 32'hAA22AA44});
        check("t3_flat_r0", {1'b0, reg_of(0)}, 33'd0);

        // 4: interrupt enable, set, W1C, set-wins
        wr("t4_ctrl", Base + 36'h0, 4'hF, 32'h1, RespOk);
        pulse_irq();
        @(negedge clk);
        check("t4_irq_early", {32'b0, irq}, 33'd0);
        @(negedge clk);
        check("t4_irq_set", {32'b0, irq}, 33'd1);
        rdc("t4_rd_stat", Base + 36'h4, {1'b0, 32'h1});
        wr("t4_w1c_nomask", Base + 36'h4, 4'h0, 32'h1, RespOk);
        check("t4_irq_nomask", {32'b0, irq}, 33'd1);
        wr("t4_w1c", Base + 36'h4, 4'h1, 32'h1, RespOk);
        check("t4_irq_clr", {32'b0, irq}, 33'd0);
        rdc("t4_rd_stat_clr", Base + 36'h4, 33'd0);
        pulse_irq();
        @(negedge clk);
        @(negedge clk);
        check("t4_irq_set2", {32'b0, irq}, 33'd1);
        bus("t4_w1c_race", 1'b0, 4'h1, Base + 36'h4, 32'h1, 0, 1'b1, 1'b0, 4'd0, 32'h0,
            RespOk);
        rdc("t4_rd_stat_race", Base + 36'h4, {1'b0, 32'h1});
        check("t4_irq_race", {32'b0, irq}, 33'd1);

        // 5: response held while read_req low; competing request must wait
        bus("t5", 1'b1, 4'h0, Base + 36'hC, 32'h0, 10, 1'b0, 1'b0, 4'd0, 32'h0,
            {1'b0, 32'hAA22AA44});
        check("t5_r2_kept", {1'b0, reg_of(2)}, {1'b0, 32'hDEADBEEF});

        // 6: hw port collisions and protected indices
        bus("t6_coll", 1'b0, 4'hF, Base + 36'h14, 32'h77, 0, 1'b0, 1'b1, 4'd5, 32'h55,
            RespOk);
        rdc("t6_rd_r5", Base + 36'h14, {1'b0, 32'h77});
        hw_poke(4'd6, 32'h66);
        check("t6_hw_r6", {1'b0, reg_of(6)}, {1'b0, 32'h66});
        hw_poke(4'd0, 32'hFFFFFFFF);
        check("t6_hw_ctrl", {1'b0, reg_of(0)}, {1'b0, 32'h1});
        hw_poke(4'd1, 32'h0);
        check("t6_hw_stat", {1'b0, reg_of(1)}, {1'b0, 32'h1});

        // Reset during ACCESS: transaction dropped
        @(negedge clk);
        req      = 1'b1;
        req_data = {1'b0, 1'b0, 4'hF, Base + 36'h14, 32'h99};
        begin
            int n;
            n = 0;
            while (wr_ack !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("t6_rst_accept", {32'b0, wr_ack}, 33'd1);
        end
        @(posedge clk);
        #1;
        req   = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_rst_rack", {32'b0, rd_ack}, 33'd0);
        end
        check("t6_rst_flat", {32'b0, regs_flat != '0}, 33'd0);
        check("t6_rst_busy", {32'b0, busy}, 33'd0);
        check("t6_rst_irq", {32'b0, irq}, 33'd0);
        rdc("t6_rst_rd_r5", Base + 36'h14, 33'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/afb_accel_regfile.md
Name: afb_accel_regfile

Overview:
- Parametrised AFB slave register file; next-generation control/status front end for AJIT accelerators.
- Sits between the AJIT core AFB request/response pipes and accelerator datapath logic.
- Adds over the previous generation:
  - configurable register count and base address
  - byte-masked writes and error responses for bad addresses
  - a response for every request
  - hardware-side register update port
  - maskable, W1C-clearable interrupt

Parameters:
NUM_REGS, 16, number of 32-bit registers; power of 2, minimum 4.
BASE_ADDR, 36'h0, byte address of register 0; aligned to 4*NUM_REGS.
IDX_W, log2(NUM_REGS), register index width (derived).

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
afb_req_write_req  in  1  core offers request.
afb_req_write_ack  out  1  block accepts request.
afb_req_write_data  in  74  [73] lock (ignored), [72] 1=read/0=write, [71:68] byte mask, [67:32] address, [31:0] write data.
afb_resp_read_req  in  1  core ready for response.
afb_resp_read_ack  out  1  response valid.
afb_resp_read_data  out  33  [32] error, [31:0] read data.
hw_wr_en  in  1  datapath register update strobe.
hw_wr_idx  in  IDX_W  register index for hw update.
hw_wr_data  in  32  hw update value.
irq_set  in  1  pulse; sets IRQ_STATUS[0].
regs_flat  out  32*NUM_REGS  all register values; reg i at [32i+31:32i].
busy  out  1  high when not in IDLE.
accelerator_interrupt  out  1  CTRL[0] & IRQ_STATUS[0], registered.

Behaviour:
- Reset values:
  - all registers 0
  - afb_req_write_ack = 0, afb_resp_read_ack = 0, afb_resp_read_data = 0
  - busy = 0, accelerator_interrupt = 0
  - state = IDLE
- Handshake: a transfer occurs in a cycle where req and ack are both 1. The ack never depends combinationally on req.
- FSM:
  - IDLE: write_ack = 1. On write_req, latch the 74-bit request and go to ACCESS.
  - ACCESS (1 cycle, write_ack = 0):
    - Decode the address and perform the write/read; latch the 33-bit response.
    - Go to RESP.
  - RESP:
    - read_ack = 1 with stable data.
    - On read_req & read_ack, go to IDLE with read_ack = 0 next cycle.
    - Hold indefinitely while read_req = 0.
- Latency: request accepted at cycle N; response visible from N+2. Minimum back-to-back spacing is 3 cycles.
- Decode:
  - Hit when address in [BASE_ADDR, BASE_ADDR + 4*NUM_REGS - 1] and address[1:0] == 0.
  - Index = address[IDX_W+1:2].
  - Miss: response {1, 32'h0}; no register modified.
- Write:
  - Byte k (bits 8k+7:8k) is updated only if mask[k] = 1. Mask 0000 is a legal no-op.
  - Response {0, 32'h0}.
- Read: response {0, reg[idx]}; the mask is ignored.
- Register map:
  - Reg 0 CTRL: RW; bit0 = IRQ_EN.
  - Reg 1 IRQ_STATUS:
    - Bus write is W1C (masked bytes only).
    - irq_set sets bit0.
    - If set and clear occur in the same cycle, set wins.
    - Other bits read 0.
  - Regs 2..NUM_REGS-1: RW.
- Hardware port:
  - hw_wr_en writes the full 32 bits to regs 2..NUM_REGS-1.
  - hw writes to index 0 or 1 are ignored.
  - If a bus write in ACCESS targets the same register in the same cycle, the bus write wins.
- regs_flat reflects register state registered (one cycle after the update edge).
- Interrupt: registered; asserts the cycle after CTRL[0] & IRQ_STATUS[0] becomes true.
- Reset mid-transaction: the transaction is dropped, no response is issued, and the FSM returns to IDLE.

Decomposition:
- Package afb_pkg:
  - field positions: RW bit 72, MASK 71:68, ADDR 67:32, WDATA 31:0, RESP_ERR 32
  - state encoding IDLE/ACCESS/RESP
  - register index constants CTRL = 0, IRQ_STATUS = 1
- Sub-module afb_addr_decode (combinational): address, BASE_ADDR, NUM_REGS → hit, idx.

Test Plan:
1. Write addr BASE+8, mask 1111, data 32'hDEADBEEF; then read BASE+8 → write response {0,0}; read response {0, 32'hDEADBEEF} at N+2.
2. Write BASE+12 mask 0101 data 32'h11223344 over 32'hAAAAAAAA → read returns 32'hAA22AA44.
3. Read BASE+4*NUM_REGS (=BASE+64), and separately read BASE+6 → both responses {1, 32'h0}; no register change.
4. CTRL = 1, pulse irq_set → interrupt = 1 one cycle later; write IRQ_STATUS data 1 mask 0001 → interrupt = 0; repeat with irq_set in the W1C cycle → bit stays 1.
5. Hold read_req = 0 for 10 cycles in RESP → read_ack and data stable, write_ack = 0, busy = 1; a second write_req is not accepted until the response completes.
6. hw_wr_en idx 5 data 32'h55 coincident with bus write idx 5 data 32'h77 → reg5 = 32'h77; hw write to idx 0 → CTRL unchanged; reset asserted in ACCESS → no response, all registers 0.
